// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, FSM states and lane helpers for the load/store unit.
package mem_access_unit_pkg;

  localparam int unsigned OP_STORE = 3;
  localparam int unsigned OP_UNS   = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Attributes of the in-flight request needed after the bus handshake.
  typedef struct packed {
    logic       store;
    logic       uns;
    logic [1:0] size;
    logic [1:0] lane;
  } req_t;

  // Size 3 is always illegal; halves need even, words need 4-byte alignment.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane;
      default: return 1'b1;
    endcase
  endfunction

  // Little-endian byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'(4'b0001 << lane);
      SZ_H:    return 4'(4'b0011 << lane);
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand so every candidate lane carries it.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_access_unit_load_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] value
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_B:    value = uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
      SZ_H:    value = uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one data-memory transaction per request with lane steering,
// alignment check and bus timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  req_t               req_q, req_d;
  logic [31:0]        ext_c;

  logic               busy_d, done_d, addr_err_d, bus_err_d;
  logic               mem_req_d, mem_we_d;
  logic [31:0]        rdata_d, mem_addr_d, mem_wdata_d;
  logic [3:0]         mem_wmask_d;

  mem_access_unit_load_extract u_extract (
    .word  (mem_rdata),
    .lane  (req_q.lane),
    .size  (req_q.size),
    .uns   (req_q.uns),
    .value (ext_c)
  );

  // State, counter, latched request and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_q     <= req_d;
      busy      <= busy_d;
      done      <= done_d;
      rdata     <= rdata_d;
      addr_err  <= addr_err_d;
      bus_err   <= bus_err_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wmask <= mem_wmask_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Next state and next output values; bus outputs are only non-zero in REQ.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    req_d       = req_q;
    done_d      = 1'b0;
    rdata_d     = '0;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wmask_d = '0;
    mem_wdata_d = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          req_d.store = op[OP_STORE];
          req_d.uns   = op[OP_UNS];
          req_d.size  = op[1:0];
          req_d.lane  = addr[1:0];
          if (is_illegal(op[1:0], addr[1:0])) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = op[OP_STORE];
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wmask_d = op[OP_STORE] ? lane_mask(op[1:0], addr[1:0]) : 4'b0000;
            mem_wdata_d = op[OP_STORE] ? lane_data(op[1:0], wdata) : 32'd0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          rdata_d = req_q.store ? 32'd0 : ext_c;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d       = cnt + CNT_W'(1);
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we;
          mem_addr_d  = mem_addr;
          mem_wmask_d = mem_wmask;
          mem_wdata_d = mem_wdata;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: lane steering, extension, errors, abort.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, addr_err, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
    op = o; addr = a; wdata = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (mem_req !== 1'b0)  begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (rdata !== 32'd0)   begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_lb();
    issue(4'b0000, 32'h0000_0103, 32'd0);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lb_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL lb_mem_addr got=%h exp=00000100", mem_addr); end
    total++; if (mem_we !== 1'b0 || mem_wmask !== 4'b0000) begin bad++; $display("FAIL lb_we_mask got=%b/%b exp=0/0000", mem_we, mem_wmask); end
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL lb_busy_done got=%b/%b exp=1/0", busy, done); end
    mem_ack = 1'b1; mem_rdata = 32'h8000_0000;
    tick();
    mem_ack = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL lb_done got=%b exp=1", done); end
    total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
    total++; if (addr_err !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL lb_errs got=%b/%b exp=0/0", addr_err, bus_err); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lb_req_drop got=%b exp=0", mem_req); end
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL lb_idle got=%b/%b/%h exp=0/0/0", done, busy, rdata); end
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops [4] = '{4'b0101, 4'b0001, 4'b0100, 4'b0000};
    logic [31:0] as  [4] = '{32'h202, 32'h202, 32'h201, 32'h200};
    logic [31:0] exp [4] = '{32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_0012, 32'h0000_0034};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF_1234;
      tick();
      mem_ack = 1'b0;
      total++; if (done !== 1'b1 || rdata !== exp[i]) begin bad++; $display("FAIL load_ext[%0d] got=%b/%h exp=1/%h", i, done, rdata, exp[i]); end
      tick();
    end
  endtask

  task automatic test_store();
    logic [3:0]  ops [3] = '{4'b1000, 4'b1001, 4'b1010};
    logic [31:0] as  [3] = '{32'h301, 32'h302, 32'h400};
    logic [31:0] ds  [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'hDEAD_BEEF};
    logic [3:0]  em  [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ed  [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'hDEAD_BEEF};
    logic [31:0] ea  [3] = '{32'h300, 32'h300, 32'h400};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], ds[i]);
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL store_req[%0d] got=%b/%b exp=1/1", i, mem_req, mem_we); end
      total++; if (mem_wmask !== em[i] || mem_wdata !== ed[i] || mem_addr !== ea[i]) begin
        bad++; $display("FAIL store_lane[%0d] got=%b/%h/%h exp=%b/%h/%h", i, mem_wmask, mem_wdata, mem_addr, em[i], ed[i], ea[i]);
      end
      tick();
      total++; if (mem_wmask !== em[i] || mem_wdata !== ed[i] || mem_req !== 1'b1) begin bad++; $display("FAIL store_hold[%0d] got=%b/%h/%b exp=%b/%h/1", i, mem_wmask, mem_wdata, mem_req, em[i], ed[i]); end
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_ack = 1'b0;
      total++; if (done !== 1'b1 || rdata !== 32'd0) begin bad++; $display("FAIL store_done[%0d] got=%b/%h exp=1/0", i, done, rdata); end
      tick();
    end
  endtask

  task automatic test_addr_err();
    logic [3:0]  ops [3] = '{4'b1010, 4'b0011, 4'b0001};
    logic [31:0] as  [3] = '{32'h402, 32'h000, 32'h101};
    int req_seen;
    for (int i = 0; i < 3; i++) begin
      req_seen = 0;
      issue(ops[i], as[i], 32'hFFFF_FFFF);
      if (mem_req) req_seen++;
      total++; if (done !== 1'b1 || addr_err !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL addr_err[%0d] got=%b/%b/%b exp=1/1/0", i, done, addr_err, bus_err); end
      tick();
      if (mem_req) req_seen++;
      total++; if (req_seen !== 0 || done !== 1'b0 || addr_err !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL addr_err_after[%0d] got=req%0d/%b/%b/%b exp=req0/0/0/0", i, req_seen, done, addr_err, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int guard = 0;
    issue(4'b0010, 32'h500, 32'd0);
    mem_rdata = 32'h1111_1111;
    while (!done && guard < 40) begin
      if (mem_req) req_cycles++;
      tick();
      guard++;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL timeout_bound got=done%b exp=done1", done); end
    total++; if (req_cycles !== 16) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=16", req_cycles); end
    total++; if (bus_err !== 1'b1 || rdata !== 32'd0 || mem_req !== 1'b0) begin bad++; $display("FAIL timeout_flags got=%b/%h/%b exp=1/0/0", bus_err, rdata, mem_req); end
    tick();
    total++; if (bus_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b/%b exp=0/0", bus_err, busy); end
  endtask

  task automatic test_ack_last();
    issue(4'b0010, 32'h600, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    total++; if (mem_req !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ack_last_pre got=%b/%b exp=1/0", mem_req, done); end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    total++; if (done !== 1'b1 || bus_err !== 1'b0 || rdata !== 32'h1234_5678) begin bad++; $display("FAIL ack_last got=%b/%b/%h exp=1/0/12345678", done, bus_err, rdata); end
    tick();
  endtask

  task automatic test_abort();
    int done_seen = 0;
    issue(4'b0010, 32'h700, 32'd0);
    tick(); tick();
    // start while busy is ignored: an illegal op here must not raise addr_err
    op = 4'b0011; start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort got=%b/%b/%b exp=0/0/0", busy, mem_req, done); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
  endtask

  task automatic test_back_to_back();
    int done_seen = 0;
    issue(4'b0010, 32'h800, 32'd0);
    // start held during REQ with an illegal op must be ignored
    op = 4'b0011; start = 1'b1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin bad++; $display("FAIL fresh_req got=%b/%h exp=1/00000800", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    total++; if (done !== 1'b1 || rdata !== 32'hCAFE_F00D || addr_err !== 1'b0) begin bad++; $display("FAIL fresh_lw got=%b/%h/%b exp=1/cafef00d/0", done, rdata, addr_err); end
    // start still high in the DONE cycle: ignored, unit returns to idle
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL done_start_ignored got=%b/%b exp=0/0", busy, done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    total++; if (done_seen !== 0) begin bad++; $display("FAIL no_spurious_done got=%0d exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_load_ext();
    test_store();
    test_addr_err();
    test_timeout();
    test_ack_last();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
